// File: rtl/hack_memory_bank_if.sv
// Bus bundle for hack_memory_bank: bit register, word register and RAM ports.
interface hack_memory_bank_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
);
    logic                  bit_in;
    logic                  bit_load;
    logic                  bit_out;
    logic [DATA_WIDTH-1:0] reg_in;
    logic                  reg_load;
    logic [DATA_WIDTH-1:0] reg_out;
    logic [DATA_WIDTH-1:0] ram_in;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic                  ram_load;
    logic [DATA_WIDTH-1:0] ram_out;

    modport master (
        output bit_in, bit_load, reg_in, reg_load, ram_in, ram_address, ram_load,
        input  bit_out, reg_out, ram_out
    );

    modport slave (
        input  bit_in, bit_load, reg_in, reg_load, ram_in, ram_address, ram_load,
        output bit_out, reg_out, ram_out
    );
endinterface

// File: rtl/hack_memory_bank.sv
// Hack leaf storage: 1-bit register, word register and 2**ADDR_WIDTH-word RAM.
// Define HACK_MEMORY_BANK_RAM_OUT_REG_EN for a registered (1-cycle) RAM read.
module hack_memory_bank #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic            clock,
    input  logic            reset_n,
    hack_memory_bank_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic                  bit_q = 1'b0;
    logic [DATA_WIDTH-1:0] reg_q = '0;
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            bit_q <= 1'b0;
            reg_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (bus.bit_load) begin
                bit_q <= bus.bit_in;
            end
            if (bus.reg_load) begin
                reg_q <= bus.reg_in;
            end
            if (bus.ram_load) begin
                mem[bus.ram_address] <= bus.ram_in;
            end
        end
    end

    assign bus.bit_out = bit_q;
    assign bus.reg_out = reg_q;

`ifdef HACK_MEMORY_BANK_RAM_OUT_REG_EN
    logic [DATA_WIDTH-1:0] ram_q = '0;

    // Reads the pre-write contents, so a same-edge write shows up one cycle later.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ram_q <= '0;
        end else begin
            ram_q <= mem[bus.ram_address];
        end
    end

    assign bus.ram_out = ram_q;
`else
    assign bus.ram_out = mem[bus.ram_address];
`endif
endmodule

// File: tb/tb_hack_memory_bank.sv
// Randomised self-checking bench for hack_memory_bank against an array-based model.
module tb_hack_memory_bank;
    localparam int DW = 16;
    localparam int AW = 3;
    localparam int DEPTH = 2 ** AW;

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic          m_bit = 1'b0;
    logic [DW-1:0] m_reg = '0;
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_ramq = '0;

    hack_memory_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    hack_memory_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_ram();
`ifdef HACK_MEMORY_BANK_RAM_OUT_REG_EN
        return m_ramq;
`else
        return m_mem[bus.ram_address];
`endif
    endfunction

    task automatic check_all(input string tag);
        check_eq({tag, ".bit"}, {31'd0, bus.bit_out}, {31'd0, m_bit});
        check_eq({tag, ".reg"}, {16'd0, bus.reg_out}, {16'd0, m_reg});
        check_eq({tag, ".ram"}, {16'd0, bus.ram_out}, {16'd0, exp_ram()});
    endtask

    // One rising edge: advance the model with the inputs present at the edge, then compare.
    task automatic edge_step(input string tag);
        logic [DW-1:0] old_word;
        @(posedge clock);
        old_word = m_mem[bus.ram_address];
        if (!reset_n) begin
            m_bit = 1'b0;
            m_reg = '0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            m_ramq = '0;
        end else begin
            if (bus.bit_load) m_bit = bus.bit_in;
            if (bus.reg_load) m_reg = bus.reg_in;
            if (bus.ram_load) m_mem[bus.ram_address] = bus.ram_in;
            m_ramq = old_word;
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        bus.bit_load = 1'b0;
        bus.reg_load = 1'b0;
        bus.ram_load = 1'b0;
    endtask

    task automatic read_sweep(input string tag);
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) begin
            bus.ram_address = AW'(i);
            bus.ram_in = DW'(8 * i);
`ifndef HACK_MEMORY_BANK_RAM_OUT_REG_EN
            #1;
            check_eq({tag, ".comb"}, {16'd0, bus.ram_out}, {16'd0, m_mem[i]});
`endif
            edge_step(tag);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        bus.bit_in = 1'b0;
        bus.reg_in = '0;
        bus.ram_in = '0;
        bus.ram_address = '0;
        idle_inputs();
        #1;
        check_all("powerup");

        reset_n = 1'b0;
        edge_step("reset");
        reset_n = 1'b1;
        read_sweep("reset_sweep");

        bus.bit_in = 1'b1; bus.bit_load = 1'b1;
        edge_step("bit_set");
        bus.bit_in = 1'b0; bus.bit_load = 1'b0;
        edge_step("bit_hold1");
        edge_step("bit_hold2");
        check_eq("bit_still1", {31'd0, bus.bit_out}, 32'd1);
        bus.bit_load = 1'b1;
        edge_step("bit_clear");
        bus.bit_in = 1'b1; bus.bit_load = 1'b0;
        edge_step("bit_hold0");
        check_eq("bit_still0", {31'd0, bus.bit_out}, 32'd0);

        bus.reg_in = 16'h3524; bus.reg_load = 1'b1;
        edge_step("reg_load1");
        check_eq("reg_3524", {16'd0, bus.reg_out}, 32'h3524);
        bus.reg_in = 16'h1A92; bus.reg_load = 1'b0;
        edge_step("reg_hold");
        check_eq("reg_held", {16'd0, bus.reg_out}, 32'h3524);
        bus.reg_load = 1'b1;
        edge_step("reg_load2");
        check_eq("reg_1A92", {16'd0, bus.reg_out}, 32'h1A92);
        bus.reg_load = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            bus.ram_address = AW'(i);
            bus.ram_in = DW'(4 * i);
            bus.ram_load = 1'b1;
            edge_step("fill");
        end
        read_sweep("fill_read");

        bus.ram_address = 3'd5; bus.ram_in = 16'hBEEF; bus.ram_load = 1'b1;
        edge_step("beef_write");
        bus.ram_in = '0; bus.ram_load = 1'b0;
        edge_step("beef_noload");
        read_sweep("beef_iso");
        check_eq("beef_kept", {16'd0, m_mem[5]}, 32'hBEEF);

`ifdef HACK_MEMORY_BANK_RAM_OUT_REG_EN
        bus.ram_address = 3'd2;
        edge_step("lag_a");
        bus.ram_address = 3'd6;
        #1;
        check_eq("lag_before", {16'd0, bus.ram_out}, 32'd8);
        edge_step("lag_after");
        check_eq("lag_new", {16'd0, bus.ram_out}, 32'd24);
`endif

        bus.reg_in = 16'hFFFF; bus.reg_load = 1'b1;
        bus.ram_in = 16'h7777; bus.ram_load = 1'b1; bus.ram_address = 3'd3;
        reset_n = 1'b0;
        edge_step("rst_prio");
        check_eq("rst_prio_reg", {16'd0, bus.reg_out}, 32'd0);
        reset_n = 1'b1;
        read_sweep("rst_prio_sweep");

        for (int n = 0; n < 400; n++) begin
            bus.bit_in      = 1'($urandom);
            bus.bit_load    = 1'($urandom);
            bus.reg_in      = DW'($urandom);
            bus.reg_load    = 1'($urandom);
            bus.ram_in      = DW'($urandom);
            bus.ram_address = AW'($urandom);
            bus.ram_load    = 1'($urandom);
            reset_n         = ($urandom_range(0, 31) != 0);
            edge_step("rnd");
`ifndef HACK_MEMORY_BANK_RAM_OUT_REG_EN
            bus.ram_address = AW'($urandom);
            #1;
            check_eq("rnd_addr", {16'd0, bus.ram_out}, {16'd0, m_mem[bus.ram_address]});
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
